// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, LSB first, one full-subtractor cell
// reused every clock with a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ser_d,
    output logic             ser_valid
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             cell_diff, cell_borrow;
    logic             last_bit;

    // Returns {borrow, diff} for x - y - r.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic r);
        logic df, bo;
        df = x ^ y ^ r;
        bo = (~x & y) | (~(x ^ y) & r);
        return {bo, df};
    endfunction

    always_comb begin
        {cell_borrow, cell_diff} = full_sub(sa[0], sb[0], br);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, serial cell update, result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            d         <= '0;
            bout      <= 1'b0;
            done      <= 1'b0;
            ser_d     <= 1'b0;
            ser_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    ser_d     <= 1'b0;
                    ser_valid <= 1'b0;
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        br   <= bin;
                        cnt  <= '0;
                        d    <= '0;
                        bout <= 1'b0;
                    end
                end
                RUN: begin
                    // Bits enter at the MSB so bit 0 lands in d[0] after WIDTH shifts.
                    d         <= {cell_diff, d[WIDTH-1:1]};
                    sa        <= sa >> 1;
                    sb        <= sb >> 1;
                    br        <= cell_borrow;
                    cnt       <= cnt + 1'b1;
                    ser_d     <= cell_diff;
                    ser_valid <= 1'b1;
                    if (last_bit) begin
                        bout <= cell_borrow;
                        done <= 1'b1;
                    end
                end
                default: begin
                    done      <= 1'b0;
                    ser_d     <= 1'b0;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8) with
// hand-written sequences for ignored start, held start and mid-run reset.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout, ser_d, ser_valid;
    logic [W-1:0] d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bout;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .bout      (bout),
        .ser_d     (ser_d),
        .ser_valid (ser_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One full operation; inputs are scrambled during RUN, and with disturb a
    // second start (with different operands) is pulsed mid-run.
    task automatic run_op(input vec_t v, input bit disturb);
        logic [W-1:0] ser;
        ser   = '0;
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_at_accept", busy, 1);
        chk("d_cleared", d, 0);
        chk("bout_cleared", bout, 0);
        chk("ser_valid_at_accept", ser_valid, 0);
        for (int i = 1; i <= W; i++) begin
            if (disturb && i == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
                bin   = 1'b1;
            end else begin
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
                bin   = 1'($urandom);
            end
            @(posedge clk); #1;
            chk("ser_valid_run", ser_valid, 1);
            chk("busy_run", busy, 1);
            chk("done_timing", done, (i == W));
            ser[i-1] = ser_d;
        end
        start = 1'b0;
        chk("d_result", d, v.exp_d);
        chk("bout_result", bout, v.exp_bout);
        chk("ser_stream", ser, v.exp_d);
        @(posedge clk); #1;
        chk("done_cleared", done, 0);
        chk("busy_cleared", busy, 0);
        chk("ser_valid_cleared", ser_valid, 0);
        chk("ser_d_cleared", ser_d, 0);
        chk("d_held", d, v.exp_d);
        chk("bout_held", bout, v.exp_bout);
    endtask

    initial begin
        int last_j, npulse, first_j;
        vec_t v;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h5A, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ser_d", ser_d, 0);
        chk("rst_ser_valid", ser_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) run_op(vecs[k], 1'b0);

        // Start pulsed during RUN must be dropped, not queued.
        v = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        run_op(v, 1'b1);
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            chk("no_queued_done", done, 0);
            chk("no_queued_busy", busy, 0);
        end

        // Start held high: re-accepted every WIDTH+2 cycles.
        a       = 8'h09;
        b       = 8'h04;
        bin     = 1'b0;
        start   = 1'b1;
        last_j  = -1;
        first_j = -1;
        npulse  = 0;
        for (int j = 0; j <= 28; j++) begin
            @(posedge clk); #1;
            if (done) begin
                npulse++;
                chk("held_d", d, 8'h05);
                chk("held_bout", bout, 0);
                if (last_j >= 0) chk("held_spacing", j - last_j, 10);
                else first_j = j;
                last_j = j;
            end
        end
        start = 1'b0;
        chk("held_pulses", npulse, 3);
        chk("held_first_latency", first_j, 8);
        @(posedge clk); #1;
        chk("held_idle", busy, 0);
        @(posedge clk); #1;
        chk("held_not_reaccepted", busy, 0);

        // Asynchronous reset in the fourth RUN cycle.
        a     = 8'h5A;
        b     = 8'h0F;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_d", d, 0);
        chk("arst_bout", bout, 0);
        chk("arst_ser_d", ser_d, 0);
        chk("arst_ser_valid", ser_valid, 0);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("arst_hold_done", done, 0);
            chk("arst_hold_busy", busy, 0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            chk("no_resume_done", done, 0);
            chk("no_resume_busy", busy, 0);
        end
        v = '{8'h07, 8'h02, 1'b0, 8'h05, 1'b0};
        run_op(v, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
